comms_ctrl: RTL and testbench
=============================

// Module: comms_ctrl
// PURPOSE
//  Command layer between the chip's uart_rx/uart_tx and the config regfile.
//  - Unloads 18-bit packets {parity[17], addr[16:9], data[8:1], wrb[0]} from uart_rx.
//  - Checks odd parity, then performs the regfile write or read.
//  - Returns read results to the host via uart_tx.
// PARAMETERS
//  NUMREGS   32  number of implemented regfile addresses (0..NUMREGS-1)
//  CNT_W     8   width of the saturating parity-error counter
// PORTS
//  clk             in   1      system clock
//  reset           in   1      synchronous reset, active high
//  rx_data         in   18     received packet from uart_rx
//  rx_empty        in   1      uart_rx: low = packet waiting
//  uld_rx_data     out  1      one-cycle unload strobe to uart_rx
//  tx_data         out  18     reply packet to uart_tx
//  ld_tx_data      out  1      load request to uart_tx (level, handshaken)
//  tx_busy         in   1      uart_tx busy
//  reg_addr        out  8      regfile address
//  reg_wr_data     out  8      regfile write data
//  reg_we          out  1      regfile write enable, one-cycle pulse
//  reg_rd_data     in   8      regfile read data (combinational from reg_addr)
//  parity_err_cnt  out  CNT_W  saturating count of rejected packets
//  busy            out  1      high whenever state != IDLE
// BEHAVIOUR
//  Reset: all outputs 0, pkt register 0, state=IDLE, parity_err_cnt=0. All outputs are registered.
//  Reset asserted in any state: abort on that edge.
//  - No reg_we or ld_tx_data afterwards; any in-flight packet is dropped.
//  FSM states: IDLE, UNLOAD, CAPTURE, CHECK, WRITE, READ, TX_WAIT, TX_HOLD.
//  IDLE: rx_empty==0 -> UNLOAD. uld_rx_data is high for exactly the UNLOAD cycle.
//  UNLOAD -> CAPTURE: pkt <= rx_data, sampled at the end of CAPTURE (one cycle after the strobe).
//  CHECK:
//  - If ^pkt==0 (even parity): increment parity_err_cnt, saturating at 2^CNT_W-1, -> IDLE.
//  - Else if wrb==0 (write) -> WRITE.
//  - Else (read) -> READ.
//  WRITE: reg_addr=pkt addr, reg_wr_data=pkt data, reg_we=1 for one cycle, -> IDLE.
//  - reg_we rises 3 cycles after the uld_rx_data cycle.
//  - addr>=NUMREGS: no reg_we pulse, silently dropped, -> IDLE.
//  - Writes never generate a reply.
//  READ: reg_addr=pkt addr; reg_rd_data captured at the end of the cycle.
//  - addr>=NUMREGS: captured data forced to 0x00.
//  - Reply word = {p, addr, rdata, 1'b1}, with p chosen so ^reply==1. -> TX_WAIT.
//  TX_WAIT: wait while tx_busy==1; when tx_busy==0 set ld_tx_data=1 -> TX_HOLD.
//  TX_HOLD: hold ld_tx_data=1 and tx_data stable until tx_busy==1.
//  - Then deassert ld_tx_data -> IDLE.
//  - No timeout.
//  rx_empty low while not in IDLE: ignored until IDLE. Packets queue in uart_rx, never in this block.
//  Back-to-back packets: IDLE is occupied >=1 cycle between packets. Min write turnaround is 5 cycles.
//  parity_err_cnt clears only on reset.
// TESTING
//  1. rx_data=0x20356 (write addr 0x01 data 0xAB) -> reg_we pulse with reg_addr=0x01, reg_wr_data=0xAB;
//     pulse 3 cycles after uld; no ld_tx_data.
//  2. Regfile[0x01]=0xAB, rx_data=0x20201 (read 0x01) -> ld_tx_data with tx_data=0x00357.
//  3. rx_data=0x00356 (bad parity) -> no reg_we, no reply, parity_err_cnt 0->1.
//     300 bad packets -> counter saturates at 0xFF.
//  4. rx_data=0x24001 (read addr 0x20, out of range) -> reply 0x24001.
//     Write to 0x20 -> no reg_we.
//  5. tx_busy held 1 for 50 cycles during a read -> ld_tx_data stays 0 until tx_busy falls.
//     Then ld_tx_data held until tx_busy rises; tx_data stable throughout.
//  6. Reset asserted in CHECK and again in TX_HOLD -> next cycle all outputs 0, state IDLE, busy=0.
//     Counter cleared; next valid packet processed normally.

Source files
------------

// File: rtl/comms_ctrl.sv
// ----------------------------------------------------------------------------
// comms_ctrl
//   Command layer between uart_rx/uart_tx and the configuration regfile.
//   Unloads 18-bit packets {parity, addr[7:0], data[7:0], wrb} from uart_rx,
//   checks odd parity, then performs a regfile write or read. Read results
//   go back to the host through uart_tx as {parity, addr, rdata, 1'b1}.
//
// Ports
//   clk            system clock
//   reset          synchronous reset, active high
//   rx_data        received packet from uart_rx
//   rx_empty       uart_rx status, low when a packet is waiting
//   uld_rx_data    one-cycle unload strobe to uart_rx
//   tx_data        reply packet to uart_tx
//   ld_tx_data     load request to uart_tx, held until tx_busy rises
//   tx_busy        uart_tx busy
//   reg_addr       regfile address
//   reg_wr_data    regfile write data
//   reg_we         regfile write enable, one-cycle pulse
//   reg_rd_data    regfile read data, combinational from reg_addr
//   parity_err_cnt saturating count of packets rejected for bad parity
//   busy           high whenever the controller is not idle
// ----------------------------------------------------------------------------
module comms_ctrl #(
    parameter int NUMREGS = 32,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [17:0]      rx_data,
    input  logic             rx_empty,
    output logic             uld_rx_data,
    output logic [17:0]      tx_data,
    output logic             ld_tx_data,
    input  logic             tx_busy,
    output logic [7:0]       reg_addr,
    output logic [7:0]       reg_wr_data,
    output logic             reg_we,
    input  logic [7:0]       reg_rd_data,
    output logic [CNT_W-1:0] parity_err_cnt,
    output logic             busy
);

    typedef enum logic [2:0] {
        IDLE, UNLOAD, CAPTURE, CHECK, WRITE, READ, TX_WAIT, TX_HOLD
    } state_t;

    localparam logic [8:0] NUMREGS_L = 9'(NUMREGS);

    state_t      state, next_state;
    logic [17:0] pkt;
    logic [7:0]  pkt_addr;
    logic [7:0]  pkt_data;
    logic        pkt_wrb;
    logic        pkt_par_ok;
    logic        addr_ok;

    assign pkt_addr   = pkt[16:9];
    assign pkt_data   = pkt[8:1];
    assign pkt_wrb    = pkt[0];
    assign pkt_par_ok = ^pkt;
    assign addr_ok    = ({1'b0, pkt_addr} < NUMREGS_L);

    // Saturating increment: the counter sticks at all-ones.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    // Reply word with the top bit chosen so the whole word has odd parity.
    function automatic logic [17:0] make_reply(input logic [7:0] addr,
                                               input logic [7:0] rdata);
        logic [16:0] body;
        body = {addr, rdata, 1'b1};
        return {~(^body), body};
    endfunction

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (!rx_empty) next_state = UNLOAD;
            UNLOAD:  next_state = CAPTURE;
            CAPTURE: next_state = CHECK;
            CHECK: begin
                if (!pkt_par_ok)  next_state = IDLE;
                else if (!pkt_wrb) next_state = WRITE;
                else              next_state = READ;
            end
            WRITE:   next_state = IDLE;
            READ:    next_state = TX_WAIT;
            TX_WAIT: if (!tx_busy) next_state = TX_HOLD;
            TX_HOLD: if (tx_busy)  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Outputs are registered from next_state so each one is valid for
    // exactly the cycle the FSM spends in the matching state.
    always_ff @(posedge clk) begin
        if (reset) begin
            pkt            <= '0;
            uld_rx_data    <= 1'b0;
            tx_data        <= '0;
            ld_tx_data     <= 1'b0;
            reg_addr       <= '0;
            reg_wr_data    <= '0;
            reg_we         <= 1'b0;
            parity_err_cnt <= '0;
            busy           <= 1'b0;
        end else begin
            uld_rx_data <= (next_state == UNLOAD);
            ld_tx_data  <= (next_state == TX_HOLD);
            busy        <= (next_state != IDLE);
            reg_we      <= (state == CHECK) && (next_state == WRITE) && addr_ok;

            // uart_rx presents the packet one cycle after the unload strobe.
            if (state == CAPTURE) pkt <= rx_data;

            if (state == CHECK) begin
                if (!pkt_par_ok) begin
                    parity_err_cnt <= sat_inc(parity_err_cnt);
                end else begin
                    reg_addr <= pkt_addr;
                    if (!pkt_wrb) reg_wr_data <= pkt_data;
                end
            end

            // Out-of-range reads return zero rather than whatever the
            // regfile drives for an unimplemented address.
            if (state == READ)
                tx_data <= make_reply(pkt_addr, addr_ok ? reg_rd_data : 8'h00);
        end
    end

endmodule

// File: tb/tb_comms_ctrl.sv
module tb_comms_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [17:0] rx_data;
    logic        rx_empty;
    logic        uld_rx_data;
    logic [17:0] tx_data;
    logic        ld_tx_data;
    logic        tx_busy;
    logic [7:0]  reg_addr;
    logic [7:0]  reg_wr_data;
    logic        reg_we;
    logic [7:0]  reg_rd_data;
    logic [7:0]  parity_err_cnt;
    logic        busy;

    always #5 clk = ~clk;

    comms_ctrl #(.NUMREGS(32), .CNT_W(8)) dut (
        .clk            (clk),
        .reset          (reset),
        .rx_data        (rx_data),
        .rx_empty       (rx_empty),
        .uld_rx_data    (uld_rx_data),
        .tx_data        (tx_data),
        .ld_tx_data     (ld_tx_data),
        .tx_busy        (tx_busy),
        .reg_addr       (reg_addr),
        .reg_wr_data    (reg_wr_data),
        .reg_we         (reg_we),
        .reg_rd_data    (reg_rd_data),
        .parity_err_cnt (parity_err_cnt),
        .busy           (busy)
    );

    // Regfile model; unimplemented addresses read back a non-zero pattern.
    logic [7:0] mem [0:31];
    always @(posedge clk)
        if (reg_we && reg_addr < 8'd32) mem[reg_addr[4:0]] <= reg_wr_data;
    assign reg_rd_data = (reg_addr < 8'd32) ? mem[reg_addr[4:0]] : 8'hEE;

    int we_total = 0;
    int ld_total = 0;
    always @(negedge clk) begin
        if (reg_we)     we_total++;
        if (ld_tx_data) ld_total++;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] outs_or();
        return {31'd0, (uld_rx_data | (|tx_data) | ld_tx_data | (|reg_addr) |
                        (|reg_wr_data) | reg_we | (|parity_err_cnt) | busy)};
    endfunction

    // Send one packet with an auto-responding uart_tx; observe until idle.
    task automatic run_pkt(input logic [17:0] pkt,
                           output int n_uld, output int n_we,
                           output logic [7:0] waddr, output logic [7:0] wdata,
                           output int we_dly, output int n_ld,
                           output logic [17:0] txw, output bit timeout);
        int uld_cyc;
        uld_cyc = -1; n_uld = 0; n_we = 0; n_ld = 0; we_dly = -1;
        waddr = '0; wdata = '0; txw = '0; timeout = 1'b1;
        @(negedge clk);
        rx_data  = pkt;
        rx_empty = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(posedge clk); #1;
            if (uld_rx_data) begin
                n_uld++; uld_cyc = n; rx_empty = 1'b1;
            end
            if (reg_we) begin
                n_we++; waddr = reg_addr; wdata = reg_wr_data; we_dly = n - uld_cyc;
            end
            if (ld_tx_data && !tx_busy) begin
                n_ld++; txw = tx_data; tx_busy = 1'b1;
            end else if (tx_busy && !ld_tx_data) begin
                tx_busy = 1'b0;
            end
            if (uld_cyc >= 0 && n > uld_cyc && !busy && !tx_busy) begin
                timeout = 1'b0;
                break;
            end
        end
    endtask

    typedef struct {
        logic [17:0] pkt;
        bit          exp_we;
        logic [7:0]  exp_addr;
        logic [7:0]  exp_wdata;
        bit          exp_reply;
        logic [17:0] exp_tx;
        bit          exp_perr;
    } vec_t;

    vec_t vecs [8];

    int          n_uld, n_we, we_dly, n_ld, bad, we_snap, ld_snap;
    logic [7:0]  waddr, wdata;
    logic [17:0] txw, held;
    bit          timeout, found;
    int          exp_cnt;

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 8'h00;

        //            pkt       we addr   wdata  rep tx        perr
        vecs[0] = '{18'h20356, 1, 8'h01, 8'hAB, 0, 18'h00000, 0}; // write 01<-AB
        vecs[1] = '{18'h20201, 0, 8'h00, 8'h00, 1, 18'h00357, 0}; // read 01
        vecs[2] = '{18'h00356, 0, 8'h00, 8'h00, 0, 18'h00000, 1}; // bad parity
        vecs[3] = '{18'h24001, 0, 8'h00, 8'h00, 1, 18'h24001, 0}; // read 20 (OOR)
        vecs[4] = '{18'h040AA, 0, 8'h00, 8'h00, 0, 18'h00000, 0}; // write 20 (OOR)
        vecs[5] = '{18'h03E78, 1, 8'h1F, 8'h3C, 0, 18'h00000, 0}; // write 1F<-3C
        vecs[6] = '{18'h23E01, 0, 8'h00, 8'h00, 1, 18'h23E79, 0}; // read 1F
        vecs[7] = '{18'h00201, 0, 8'h00, 8'h00, 0, 18'h00000, 1}; // read, bad parity

        reset = 1'b1; rx_data = '0; rx_empty = 1'b1; tx_busy = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs_zero", outs_or(), 0);
        reset = 1'b0;

        exp_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            run_pkt(vecs[i].pkt, n_uld, n_we, waddr, wdata, we_dly, n_ld, txw, timeout);
            if (vecs[i].exp_perr) exp_cnt++;
            check($sformatf("v%0d_timeout", i), timeout, 0);
            check($sformatf("v%0d_uld_pulses", i), n_uld, 1);
            check($sformatf("v%0d_we_pulses", i), n_we, vecs[i].exp_we);
            if (vecs[i].exp_we) begin
                check($sformatf("v%0d_we_addr", i), waddr, vecs[i].exp_addr);
                check($sformatf("v%0d_we_data", i), wdata, vecs[i].exp_wdata);
                check($sformatf("v%0d_we_delay", i), we_dly, 3);
            end
            check($sformatf("v%0d_ld_count", i), n_ld, vecs[i].exp_reply);
            if (vecs[i].exp_reply)
                check($sformatf("v%0d_tx_data", i), txw, vecs[i].exp_tx);
            check($sformatf("v%0d_perr_cnt", i), parity_err_cnt, exp_cnt);
        end

        // uart_tx stays busy for 50 cycles during a read.
        tx_busy = 1'b1;
        @(negedge clk);
        rx_data = 18'h20201; rx_empty = 1'b0;
        found = 1'b0;
        for (int n = 0; n < 20 && !found; n++) begin
            @(posedge clk); #1;
            if (uld_rx_data) found = 1'b1;
        end
        rx_empty = 1'b1;
        check("busy_read_uld_seen", found, 1);
        bad = 0;
        for (int n = 0; n < 50; n++) begin
            @(posedge clk); #1;
            if (ld_tx_data) bad++;
        end
        check("txwait_ld_low", bad, 0);
        check("txwait_busy_high", busy, 1);
        tx_busy = 1'b0;
        found = 1'b0;
        for (int n = 0; n < 10 && !found; n++) begin
            @(posedge clk); #1;
            if (ld_tx_data) found = 1'b1;
        end
        check("txhold_ld_rises", found, 1);
        held = tx_data;
        check("txhold_tx_data", held, 18'h00357);
        bad = 0;
        for (int n = 0; n < 10; n++) begin
            @(posedge clk); #1;
            if (!ld_tx_data || tx_data !== held) bad++;
        end
        check("txhold_stable", bad, 0);
        tx_busy = 1'b1;
        @(posedge clk); #1;
        check("txhold_ld_drops", ld_tx_data, 0);
        check("txhold_back_idle", busy, 0);
        tx_busy = 1'b0;

        // Parity-error counter saturation.
        for (int n = 0; n < 100; n++)
            run_pkt(18'h00356, n_uld, n_we, waddr, wdata, we_dly, n_ld, txw, timeout);
        check("perr_cnt_102", parity_err_cnt, 8'd102);
        for (int n = 0; n < 200; n++)
            run_pkt(18'h00356, n_uld, n_we, waddr, wdata, we_dly, n_ld, txw, timeout);
        check("perr_cnt_saturated", parity_err_cnt, 8'hFF);

        // Reset while in CHECK with a valid write to 0x02 in flight.
        we_snap = we_total;
        @(negedge clk);
        rx_data = 18'h00422; rx_empty = 1'b0;
        found = 1'b0;
        for (int n = 0; n < 20 && !found; n++) begin
            @(posedge clk); #1;
            if (uld_rx_data) found = 1'b1;
        end
        rx_empty = 1'b1;
        check("rst_check_uld_seen", found, 1);
        @(posedge clk); #1;   // CAPTURE
        @(posedge clk); #1;   // CHECK
        reset = 1'b1;
        @(posedge clk); #1;
        check("rst_check_outputs_zero", outs_or(), 0);
        reset = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("rst_check_no_we", we_total, we_snap);
        check("rst_check_mem2", mem[2], 8'h00);

        // Reset while in TX_HOLD (uart_tx never acknowledges).
        @(negedge clk);
        rx_data = 18'h23E01; rx_empty = 1'b0;
        found = 1'b0;
        for (int n = 0; n < 20 && !found; n++) begin
            @(posedge clk); #1;
            if (uld_rx_data) rx_empty = 1'b1;
            if (ld_tx_data) found = 1'b1;
        end
        rx_empty = 1'b1;
        check("rst_hold_ld_seen", found, 1);
        @(posedge clk); #1;
        check("rst_hold_ld_held", ld_tx_data, 1);
        reset = 1'b1;
        @(posedge clk); #1;
        check("rst_hold_outputs_zero", outs_or(), 0);
        ld_snap = ld_total;
        reset = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("rst_hold_no_ld", ld_total, ld_snap);

        // Normal operation resumes after reset.
        run_pkt(18'h20201, n_uld, n_we, waddr, wdata, we_dly, n_ld, txw, timeout);
        check("post_rst_read_timeout", timeout, 0);
        check("post_rst_read_ld", n_ld, 1);
        check("post_rst_read_tx", txw, 18'h00357);
        run_pkt(18'h00422, n_uld, n_we, waddr, wdata, we_dly, n_ld, txw, timeout);
        check("post_rst_write_we", n_we, 1);
        check("post_rst_write_addr", waddr, 8'h02);
        check("post_rst_write_data", wdata, 8'h11);
        check("post_rst_write_delay", we_dly, 3);
        check("post_rst_perr_cnt", parity_err_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
